i2c_slave: RTL
==============

Name: i2c_slave

Overview:
- I2C target (slave) responder: the other end of the bus from the existing I2C master.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches a 7-bit address, ACKs it, then either receives bytes into the RX FIFO (write transfer) or sends bytes from the TX FIFO (read transfer).
- Open-drain SDA only; never drives SCL (no clock stretching).

Parameters:
- SLV_ADDR, 7'h50, 7-bit own address compared against address bits [7:1].
- SYNC_STAGES, 2, number of synchronizer flops on scl_i/sda_i (legal range 2..3).

Ports:
- clk  input  1  system clock; must be ≥16× the SCL frequency.
- rst  input  1  asynchronous active-low reset.
- scl_i  input  1  bus SCL, raw.
- sda_i  input  1  bus SDA, raw.
- sda_o  output  1  SDA drive: 0 pulls low, 1 releases.
- data_out  output  8  received byte; valid while rxff_wr is high.
- rxff_wr  output  1  one-clk write strobe to the RX FIFO.
- i_rxff_full  input  1  RX FIFO full.
- data_in  input  8  TX FIFO head (first-word-fall-through); sampled while txff_rd is high.
- txff_rd  output  1  one-clk read strobe to the TX FIFO.
- i_txff_empty  input  1  TX FIFO empty.
- busy  output  1  high from addressed START until STOP/NACK/mismatch.
- rw_dir  output  1  latched R/W bit of the current transfer (1 = master reads).
- slv_done  output  1  one-clk pulse on STOP after an addressed transfer.

Behaviour:
- Reset values: sda_o=1, data_out=0, rxff_wr=0, txff_rd=0, busy=0, rw_dir=0, slv_done=0, state=IDLE, bit counter=7.
- Input path: SYNC_STAGES flops, then one history flop per line. Edge detection therefore lags the pins by SYNC_STAGES+1 clk.
  - scl_rise / scl_fall: SCL edges.
  - start: SDA falls while SCL is high.
  - stop: SDA rises while SCL is high.
- Bus timing: SDA is sampled on scl_rise. sda_o changes only on scl_fall, so it is stable through the whole SCL high phase.
- start in any state:
  - state=ADDR, counter=7, sda_o=1.
  - A repeated START mid-transfer aborts the transfer with no FIFO strobe.
- stop in any state:
  - state=IDLE, sda_o=1, busy=0.
  - slv_done pulses if busy was 1.
- States:
  - IDLE: ignores everything except start.
  - ADDR: shifts 8 bits MSB first on scl_rise. After bit 0:
    - if shift[7:1]==SLV_ADDR, latch rw_dir=shift[0], busy=1, go ADDR_ACK;
    - otherwise go IDLE, never drive the bus, wait for the next START.
  - ADDR_ACK: drive sda_o=0 on the next scl_fall; release on the following scl_fall. Next state is TX_DATA if rw_dir=1, else RX_DATA.
    - For a read, txff_rd pulses in the same clk as the releasing scl_fall (if not empty) and data_in is loaded into the shift register.
    - If the TX FIFO is empty, 8'hFF is loaded and there is no strobe.
  - RX_DATA: shift 8 bits on scl_rise. On the 8th scl_rise:
    - if !i_rxff_full: data_out=byte, rxff_wr=1 for exactly 1 clk, go RX_ACK (ACK);
    - if full: no strobe, go RX_ACK with a NACK flag set.
  - RX_ACK:
    - ACK: drive 0 for the ACK bit and return to RX_DATA, counter=7.
    - NACK: keep sda_o=1, go IDLE (busy=0) after the ACK-bit scl_fall.
  - TX_DATA: present shift[counter] on each scl_fall, MSB first; the first bit is presented at the scl_fall that ends ADDR_ACK/TX_ACK. After the 8th bit's scl_fall, release SDA and go TX_ACK.
  - TX_ACK: sample the master's ACK on scl_rise.
    - ACK (0): load the next byte on the following scl_fall (txff_rd rule as in ADDR_ACK), go TX_DATA.
    - NACK (1): release SDA, go IDLE; wait for STOP, no FIFO read.
- Simultaneous events: start/stop take priority over edge-driven shifting in the same clk. rxff_wr and txff_rd are never high together.
- Reset mid-transfer: all outputs return to reset values immediately; SDA is released.

Optional Feature:
- Macro I2C_SLAVE_GENCALL_EN.
- Defined: address byte 8'h00 (general call, write) is also ACKed and handled as RX_DATA, with rw_dir=0. Address 8'h01 is ignored.
- Undefined: only SLV_ADDR matches; 8'h00 is not ACKed.

Test Plan:
- Write 0xA0, 0x3C, 0x5A, STOP with SLV_ADDR=0x50, RX not full -> ACK on all 3 bytes; rxff_wr pulses twice with data_out 0x3C then 0x5A; slv_done=1 once; busy returns to 0.
- Read 0xA1, TX FIFO holding 0x96, 0x0F, master ACKs then NACKs -> SDA bits 10010110 then 00001111; txff_rd pulses exactly twice; SDA released after the NACK.
- Address 0xB0 (mismatch) followed by data bytes -> sda_o stays 1 throughout; no strobes; busy=0.
- Write 0xA0, 0x11 with i_rxff_full=1 -> address ACKed; data byte NACKed (SDA high at the 9th clock); no rxff_wr; busy=0.
- Read 0xA1 with an empty TX FIFO -> sends 0xFF, no txff_rd. Repeated START to 0xA0 mid-byte -> state=ADDR and the new write is ACKed.
- With I2C_SLAVE_GENCALL_EN: write 0x00, 0x06 -> both ACKed, data_out=0x06. Assert rst low mid-byte -> sda_o=1 and busy=0 in the same cycle.

Source files
------------

// File: rtl/i2c_slave.sv
// i2c_slave: oversampled I2C target with 7-bit address match, RX/TX FIFO hooks.
// Optional general-call ACK of address byte 8'h00 via I2C_SLAVE_GENCALL_EN.
//
// Ports:
//   clk, rst          system clock (>=16x SCL), async active-low reset
//   scl_i, sda_i      raw bus lines
//   sda_o             open-drain SDA drive (0 pulls low, 1 releases)
//   data_out/rxff_wr  received byte and one-clk RX FIFO write strobe
//   i_rxff_full       RX FIFO full
//   data_in/txff_rd   TX FIFO head (FWFT) and one-clk read strobe
//   i_txff_empty      TX FIFO empty
//   busy, rw_dir      addressed-transfer flag, latched R/W bit
//   slv_done          one-clk pulse on STOP ending an addressed transfer
module i2c_slave #(
  parameter logic [6:0] SLV_ADDR    = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic [7:0] data_out,
  output logic       rxff_wr,
  input  logic       i_rxff_full,
  input  logic [7:0] data_in,
  output logic       txff_rd,
  input  logic       i_txff_empty,
  output logic       busy,
  output logic       rw_dir,
  output logic       slv_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_RX_DATA,
    S_RX_ACK,
    S_TX_DATA,
    S_TX_ACK
  } state_t;

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_cnt;
  logic [7:0] r_shift;
  logic       r_ph;
  logic       r_nack;
  logic       r_sda_o;
  logic [7:0] r_data;
  logic       r_rxff_wr;
  logic       r_txff_rd;
  logic       r_busy;
  logic       r_rw;
  logic       r_done;

  logic [2:0] w_cnt_nxt;
  logic [7:0] w_shift_nxt;
  logic       w_ph_nxt;
  logic       w_nack_nxt;
  logic       w_sda_o_nxt;
  logic [7:0] w_data_nxt;
  logic       w_rxff_wr_nxt;
  logic       w_txff_rd_nxt;
  logic       w_busy_nxt;
  logic       w_rw_nxt;
  logic       w_done_nxt;

  logic       w_scl;
  logic       w_sda;
  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_start;
  logic       w_stop;
  logic [7:0] w_byte;
  logic       w_last;
  logic       w_match;
  logic [7:0] w_tx_byte;
  logic [2:0] w_cnt_m1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  // SCL must be high on both samples so an SCL edge is never read as START/STOP
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

  assign w_byte    = {r_shift[6:0], w_sda};
  assign w_last    = (r_cnt == 3'd0);
  assign w_cnt_m1  = r_cnt - 3'd1;
  assign w_tx_byte = i_txff_empty ? 8'hFF : data_in;

`ifdef I2C_SLAVE_GENCALL_EN
  assign w_match = (w_byte[7:1] == SLV_ADDR) | (w_byte == 8'h00);
`else
  assign w_match = (w_byte[7:1] == SLV_ADDR);
`endif

  // state register plus registered outputs/datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 3'd7;
      r_shift   <= 8'h00;
      r_ph      <= 1'b0;
      r_nack    <= 1'b0;
      r_sda_o   <= 1'b1;
      r_data    <= 8'h00;
      r_rxff_wr <= 1'b0;
      r_txff_rd <= 1'b0;
      r_busy    <= 1'b0;
      r_rw      <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_ph      <= w_ph_nxt;
      r_nack    <= w_nack_nxt;
      r_sda_o   <= w_sda_o_nxt;
      r_data    <= w_data_nxt;
      r_rxff_wr <= w_rxff_wr_nxt;
      r_txff_rd <= w_txff_rd_nxt;
      r_busy    <= w_busy_nxt;
      r_rw      <= w_rw_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // next state
  always_comb begin
    w_state_nxt = r_state;
    if (w_start) begin
      w_state_nxt = S_ADDR;
    end else if (w_stop) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: w_state_nxt = S_IDLE;
        S_ADDR:
          if (w_scl_rise && w_last)
            w_state_nxt = w_match ? S_ADDR_ACK : S_IDLE;
        S_ADDR_ACK:
          if (w_scl_fall && r_ph)
            w_state_nxt = r_rw ? S_TX_DATA : S_RX_DATA;
        S_RX_DATA:
          if (w_scl_rise && w_last)
            w_state_nxt = S_RX_ACK;
        S_RX_ACK:
          if (w_scl_fall && r_ph)
            w_state_nxt = r_nack ? S_IDLE : S_RX_DATA;
        S_TX_DATA:
          if (w_scl_fall && w_last)
            w_state_nxt = S_TX_ACK;
        S_TX_ACK:
          if (w_scl_fall)
            w_state_nxt = r_nack ? S_IDLE : S_TX_DATA;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // outputs and datapath next values
  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_shift_nxt   = r_shift;
    w_ph_nxt      = r_ph;
    w_nack_nxt    = r_nack;
    w_sda_o_nxt   = r_sda_o;
    w_data_nxt    = r_data;
    w_rxff_wr_nxt = 1'b0;
    w_txff_rd_nxt = 1'b0;
    w_busy_nxt    = r_busy;
    w_rw_nxt      = r_rw;
    w_done_nxt    = 1'b0;
    if (w_start) begin
      w_cnt_nxt   = 3'd7;
      w_sda_o_nxt = 1'b1;
      w_ph_nxt    = 1'b0;
    end else if (w_stop) begin
      w_sda_o_nxt = 1'b1;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = r_busy;
    end else begin
      unique case (r_state)
        S_ADDR:
          if (w_scl_rise) begin
            // counter wraps 0 -> 7, ready for the next byte
            w_shift_nxt = w_byte;
            w_cnt_nxt   = w_cnt_m1;
            if (w_last) begin
              w_ph_nxt = 1'b0;
              if (w_match) begin
                w_rw_nxt   = w_byte[0];
                w_busy_nxt = 1'b1;
              end else begin
                w_busy_nxt = 1'b0;
              end
            end
          end
        S_ADDR_ACK:
          if (w_scl_fall) begin
            if (!r_ph) begin
              w_sda_o_nxt = 1'b0;
              w_ph_nxt    = 1'b1;
            end else if (r_rw) begin
              w_shift_nxt   = w_tx_byte;
              w_sda_o_nxt   = w_tx_byte[7];
              w_cnt_nxt     = 3'd7;
              w_txff_rd_nxt = ~i_txff_empty;
            end else begin
              w_sda_o_nxt = 1'b1;
              w_cnt_nxt   = 3'd7;
            end
          end
        S_RX_DATA:
          if (w_scl_rise) begin
            w_shift_nxt = w_byte;
            w_cnt_nxt   = w_cnt_m1;
            if (w_last) begin
              w_ph_nxt = 1'b0;
              if (!i_rxff_full) begin
                w_data_nxt    = w_byte;
                w_rxff_wr_nxt = 1'b1;
                w_nack_nxt    = 1'b0;
              end else begin
                w_nack_nxt = 1'b1;
              end
            end
          end
        S_RX_ACK:
          if (w_scl_fall) begin
            if (!r_ph) begin
              w_sda_o_nxt = r_nack;
              w_ph_nxt    = 1'b1;
            end else begin
              w_sda_o_nxt = 1'b1;
              w_cnt_nxt   = 3'd7;
              if (r_nack)
                w_busy_nxt = 1'b0;
            end
          end
        S_TX_DATA:
          if (w_scl_fall) begin
            // r_cnt holds the index of the bit currently on the bus
            if (w_last) begin
              w_sda_o_nxt = 1'b1;
            end else begin
              w_cnt_nxt   = w_cnt_m1;
              w_sda_o_nxt = r_shift[w_cnt_m1];
            end
          end
        S_TX_ACK:
          if (w_scl_rise) begin
            w_nack_nxt = w_sda;
          end else if (w_scl_fall) begin
            if (r_nack) begin
              w_sda_o_nxt = 1'b1;
              w_busy_nxt  = 1'b0;
            end else begin
              w_shift_nxt   = w_tx_byte;
              w_sda_o_nxt   = w_tx_byte[7];
              w_cnt_nxt     = 3'd7;
              w_txff_rd_nxt = ~i_txff_empty;
            end
          end
        default: ;
      endcase
    end
  end

  assign sda_o    = r_sda_o;
  assign data_out = r_data;
  assign rxff_wr  = r_rxff_wr;
  assign txff_rd  = r_txff_rd;
  assign busy     = r_busy;
  assign rw_dir   = r_rw;
  assign slv_done = r_done;

endmodule
